mac_array: RTL and testbench

- Parametrised successor to the single-register multiply-accumulate atom.
- Holds NUM_ENTRIES independent state registers, selected per transaction by an index.
- Each valid transaction computes new = mux(state,0,sel1) * mux(constant,pkt_1,sel2) + mux(pkt_2,pkt_3,sel3).
- Adds a 2-stage compute pipeline, same-index read-after-write forwarding, a per-transaction clear, and optional saturation with an overflow flag. Sits in the stateful-atom slot of the packet pipeline.

---
 rtl/mac_array.sv | 133 +++++++++++++
 tb/tb_mac_array.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mac_array.sv
// Multi-entry multiply-accumulate atom with a 2-stage compute pipeline.
// Per-index state array, one-deep read-after-write bypass, per-txn clear, optional saturation.
module mac_array #(
    parameter  int COUNT_WIDTH = 32,
    parameter  int NUM_ENTRIES = 16,
    parameter  int SATURATE    = 0,
    localparam int IDX_WIDTH   = $clog2(NUM_ENTRIES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i__valid,
    input  logic [IDX_WIDTH-1:0]   i__index,
    input  logic                   i__clear,
    input  logic [COUNT_WIDTH-1:0] i__constant,
    input  logic [COUNT_WIDTH-1:0] i__pkt_1,
    input  logic [COUNT_WIDTH-1:0] i__pkt_2,
    input  logic [COUNT_WIDTH-1:0] i__pkt_3,
    input  logic                   i__sel1,
    input  logic                   i__sel2,
    input  logic                   i__sel3,
    output logic                   o__valid,
    output logic [IDX_WIDTH-1:0]   o__index,
    output logic [COUNT_WIDTH-1:0] o__read,
    output logic [COUNT_WIDTH-1:0] o__write,
    output logic                   o__overflow
);
    localparam int W = COUNT_WIDTH;

    generate
        if (NUM_ENTRIES < 2 || (NUM_ENTRIES & (NUM_ENTRIES - 1)) != 0) begin : g_bad_entries
            $error("mac_array: NUM_ENTRIES must be a power of two and at least 2");
        end
    endgenerate

    logic [W-1:0]         r_state [NUM_ENTRIES];
    logic [1:0]           r_vld_pipe;

    // Stage 0: captured transaction
    logic [IDX_WIDTH-1:0] r_s0_idx;
    logic                 r_s0_clr, r_s0_sel1, r_s0_sel2, r_s0_sel3;
    logic [W-1:0]         r_s0_const, r_s0_pkt1, r_s0_pkt2, r_s0_pkt3;

    // Stage 1: product and operands
    logic [IDX_WIDTH-1:0] r_s1_idx;
    logic                 r_s1_clr;
    logic [2*W-1:0]       r_s1_prod;
    logic [W-1:0]         r_s1_add, r_s1_old;

    logic [W-1:0]         w_s1_old, w_s1_mul_a, w_s1_mul_b, w_s1_add;
    logic [2*W-1:0]       w_s1_prod;
    logic [2*W:0]         w_s2_sum;
    logic                 w_s2_ovf;
    logic [W-1:0]         w_s2_res;

    // The txn ahead of us writes the same entry at this edge, so take its result directly.
    assign w_s1_old   = (r_vld_pipe[1] && r_s1_idx == r_s0_idx) ? w_s2_res : r_state[r_s0_idx];
    assign w_s1_mul_a = r_s0_sel1 ? '0 : w_s1_old;
    assign w_s1_mul_b = r_s0_sel2 ? r_s0_pkt1 : r_s0_const;
    assign w_s1_add   = r_s0_sel3 ? r_s0_pkt3 : r_s0_pkt2;
    assign w_s1_prod  = {{W{1'b0}}, w_s1_mul_a} * {{W{1'b0}}, w_s1_mul_b};

    assign w_s2_sum = {1'b0, r_s1_prod} + {{(W+1){1'b0}}, r_s1_add};
    assign w_s2_ovf = |w_s2_sum[2*W:W];
    assign w_s2_res = r_s1_clr ? '0 :
                      ((SATURATE != 0) && w_s2_ovf) ? {W{1'b1}} : w_s2_sum[W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_pipe <= '0;
            r_s0_idx   <= '0;
            r_s0_clr   <= 1'b0;
            r_s0_sel1  <= 1'b0;
            r_s0_sel2  <= 1'b0;
            r_s0_sel3  <= 1'b0;
            r_s0_const <= '0;
            r_s0_pkt1  <= '0;
            r_s0_pkt2  <= '0;
            r_s0_pkt3  <= '0;
            r_s1_idx   <= '0;
            r_s1_clr   <= 1'b0;
            r_s1_prod  <= '0;
            r_s1_add   <= '0;
            r_s1_old   <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[0], i__valid};
            if (i__valid) begin
                r_s0_idx   <= i__index;
                r_s0_clr   <= i__clear;
                r_s0_sel1  <= i__sel1;
                r_s0_sel2  <= i__sel2;
                r_s0_sel3  <= i__sel3;
                r_s0_const <= i__constant;
                r_s0_pkt1  <= i__pkt_1;
                r_s0_pkt2  <= i__pkt_2;
                r_s0_pkt3  <= i__pkt_3;
            end
            if (r_vld_pipe[0]) begin
                r_s1_idx  <= r_s0_idx;
                r_s1_clr  <= r_s0_clr;
                r_s1_prod <= w_s1_prod;
                r_s1_add  <= w_s1_add;
                r_s1_old  <= w_s1_old;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) r_state[i] <= '0;
        end else if (r_vld_pipe[1]) begin
            r_state[r_s1_idx] <= w_s2_res;
        end
    end

    // Result fields hold their last values across idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o__valid    <= 1'b0;
            o__index    <= '0;
            o__read     <= '0;
            o__write    <= '0;
            o__overflow <= 1'b0;
        end else begin
            o__valid <= r_vld_pipe[1];
            if (r_vld_pipe[1]) begin
                o__index    <= r_s1_idx;
                o__read     <= r_s1_old;
                o__write    <= w_s2_res;
                o__overflow <= w_s2_ovf & ~r_s1_clr;
            end
        end
    end
endmodule

// File: tb/tb_mac_array.sv
// Scoreboard bench for mac_array: wrapping and saturating 8-bit instances driven in parallel,
// checked against a sequential per-transaction reference model.
module tb_mac_array;
    localparam int W  = 8;
    localparam int NE = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_valid = 1'b0, i_clear = 1'b0;
    logic [IW-1:0] i_index = '0;
    logic [W-1:0]  i_const = '0, i_pkt1 = '0, i_pkt2 = '0, i_pkt3 = '0;
    logic          i_sel1 = 1'b0, i_sel2 = 1'b0, i_sel3 = 1'b0;

    logic          v_w, v_s, ov_w, ov_s;
    logic [IW-1:0] ix_w, ix_s;
    logic [W-1:0]  rd_w, rd_s, wr_w, wr_s;

    mac_array #(.COUNT_WIDTH(W), .NUM_ENTRIES(NE), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .i__valid(i_valid), .i__index(i_index), .i__clear(i_clear),
        .i__constant(i_const), .i__pkt_1(i_pkt1), .i__pkt_2(i_pkt2), .i__pkt_3(i_pkt3),
        .i__sel1(i_sel1), .i__sel2(i_sel2), .i__sel3(i_sel3),
        .o__valid(v_w), .o__index(ix_w), .o__read(rd_w), .o__write(wr_w), .o__overflow(ov_w));

    mac_array #(.COUNT_WIDTH(W), .NUM_ENTRIES(NE), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .i__valid(i_valid), .i__index(i_index), .i__clear(i_clear),
        .i__constant(i_const), .i__pkt_1(i_pkt1), .i__pkt_2(i_pkt2), .i__pkt_3(i_pkt3),
        .i__sel1(i_sel1), .i__sel2(i_sel2), .i__sel3(i_sel3),
        .o__valid(v_s), .o__index(ix_s), .o__read(rd_s), .o__write(wr_s), .o__overflow(ov_s));

    always #5 clk = ~clk;

    int unsigned e_cnt = 0;
    always @(posedge clk) e_cnt <= e_cnt + 1;

    typedef struct {
        int unsigned idx;
        int unsigned rd_w, wr_w, rd_s, wr_s;
        int unsigned ov_w, ov_s;
        int unsigned edge_n;
    } exp_t;

    exp_t        q[$];
    int unsigned st_w [NE];
    int unsigned st_s [NE];
    int          pass_cnt = 0, tot_cnt = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        tot_cnt++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        else pass_cnt++;
    endtask

    // One transaction on the unsigned arithmetic rules, applied in program order.
    task automatic model_step(input int unsigned old, input bit clr, input int unsigned c,
                              input int unsigned p1, input int unsigned p2, input int unsigned p3,
                              input bit s1, input bit s2, input bit s3, input bit sat,
                              output int unsigned res, output int unsigned ovf);
        int unsigned full;
        full = (s1 ? 0 : old) * (s2 ? p1 : c) + (s3 ? p3 : p2);
        ovf  = (full > 255 && !clr) ? 1 : 0;
        if (clr)            res = 0;
        else if (sat && full > 255) res = 255;
        else                res = full % 256;
    endtask

    task automatic send(input int unsigned idx, input bit clr, input int unsigned c,
                        input int unsigned p1, input int unsigned p2, input int unsigned p3,
                        input bit s1, input bit s2, input bit s3);
        exp_t e;
        e.idx    = idx;
        e.rd_w   = st_w[idx];
        e.rd_s   = st_s[idx];
        e.edge_n = e_cnt + 3;
        model_step(st_w[idx], clr, c, p1, p2, p3, s1, s2, s3, 1'b0, e.wr_w, e.ov_w);
        model_step(st_s[idx], clr, c, p1, p2, p3, s1, s2, s3, 1'b1, e.wr_s, e.ov_s);
        st_w[idx] = e.wr_w;
        st_s[idx] = e.wr_s;
        q.push_back(e);
        i_valid = 1'b1; i_index = IW'(idx); i_clear = clr;
        i_const = W'(c); i_pkt1 = W'(p1); i_pkt2 = W'(p2); i_pkt3 = W'(p3);
        i_sel1 = s1; i_sel2 = s2; i_sel3 = s3;
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_valid_w"}, v_w, 0);  chk({tag, "_valid_s"}, v_s, 0);
        chk({tag, "_index_w"}, ix_w, 0); chk({tag, "_read_w"}, rd_w, 0);
        chk({tag, "_write_w"}, wr_w, 0); chk({tag, "_ovf_w"}, ov_w, 0);
        chk({tag, "_write_s"}, wr_s, 0); chk({tag, "_ovf_s"}, ov_s, 0);
    endtask

    // Monitor: every output beat must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (v_w || v_s) begin
                if (q.size() == 0) begin
                    tot_cnt++;
                    $display("FAIL unexpected_valid: got valid w=%0b s=%0b expected none", v_w, v_s);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("valid_w", v_w, 1);          chk("valid_s", v_s, 1);
                    chk("latency", e_cnt, e.edge_n);
                    chk("index_w", ix_w, e.idx);     chk("index_s", ix_s, e.idx);
                    chk("read_w", rd_w, e.rd_w);     chk("read_s", rd_s, e.rd_s);
                    chk("write_w", wr_w, e.wr_w);    chk("write_s", wr_s, e.wr_s);
                    chk("ovf_w", ov_w, e.ov_w);      chk("ovf_s", ov_s, e.ov_s);
                end
            end else if (q.size() != 0 && e_cnt > q[0].edge_n) begin
                tot_cnt++;
                $display("FAIL missing_valid: got none at edge %0d expected output at edge %0d",
                         e_cnt, q[0].edge_n);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        for (int i = 0; i < NE; i++) begin st_w[i] = 0; st_s[i] = 0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Back-to-back on one index: bypass every cycle -> 5, 15, 35
        repeat (3) send(3, 0, 2, 0, 5, 0, 0, 0, 0);
        idle(3);

        // Interleaved independent counters
        for (int k = 0; k < 6; k++) send((k % 2 == 0) ? 1 : 2, 0, 1, 0, 1, 0, 0, 0, 0);
        idle(3);

        // 200*2 overflows 8 bits: wrap 144, saturate 255
        send(0, 0, 0, 0, 200, 0, 1, 0, 0);
        send(0, 0, 2, 0, 0, 0, 0, 0, 0);
        idle(3);

        // Clear then accumulate on the cleared entry
        send(5, 0, 0, 0, 0, 7, 1, 0, 1);
        idle(2);
        send(5, 1, 0, 0, 0, 0, 0, 0, 0);
        send(5, 0, 3, 0, 1, 0, 0, 0, 0);
        idle(3);

        // All alternate muxes: result is pkt_3 regardless of state
        send(6, 0, 0, 4, 0, 9, 1, 1, 1);
        send(6, 0, 0, 4, 0, 9, 1, 1, 1);
        idle(3);

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(3) != 0)
                send($urandom_range(NE - 1), ($urandom_range(9) == 0),
                     $urandom_range(255), $urandom_range(255), $urandom_range(255),
                     $urandom_range(255), $urandom_range(1), $urandom_range(1), $urandom_range(1));
            else
                idle(1);
        end
        idle(4);

        // Reset with two transactions in flight: they must never emerge or write
        send(4, 0, 0, 0, 0, 77, 1, 0, 1);
        send(4, 0, 0, 0, 0, 88, 1, 0, 1);
        rst = 1'b1;
        q.delete();
        for (int i = 0; i < NE; i++) begin st_w[i] = 0; st_s[i] = 0; end
        @(negedge clk);
        check_zero_outputs("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        idle(5);

        // Read back every entry via clear (o__read shows the old value)
        for (int i = 0; i < NE; i++) send(i, 1, 0, 0, 0, 0, 0, 0, 0);
        send(4, 0, 1, 0, 1, 0, 0, 0, 0);
        idle(6);

        chk("scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
